// File: rtl/sdram_cmd_monitor.sv
// Passive SDRAM command-bus monitor: decodes commands into packets, aligns read
// data to CAS latency, and queues packets behind a valid/ready handshake.
module sdram_cmd_monitor #(
  parameter int CAS_LATENCY = 3,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_cs_n,
  input  logic        sd_ras_n,
  input  logic        sd_cas_n,
  input  logic        sd_we_n,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_addr,
  input  logic [15:0] sd_dq,
  input  logic        pkt_ready,
  output logic        pkt_valid,
  output logic [31:0] pkt_timestamp,
  output logic [31:0] pkt_id,
  output logic [2:0]  pkt_command,
  output logic [1:0]  pkt_bank,
  output logic [12:0] pkt_row,
  output logic [9:0]  pkt_column,
  output logic [15:0] pkt_data,
  output logic        row_err,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] CMD_LMR   = 3'b000;
  localparam logic [2:0] CMD_REF   = 3'b001;
  localparam logic [2:0] CMD_PRE   = 3'b010;
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_READ  = 3'b101;

  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] id;
    logic [2:0]  cmd;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [9:0]  col;
    logic [15:0] data;
  } pkt_t;

  logic [31:0] r_ts;
  logic [31:0] r_id;
  logic [3:0]  r_open;
  logic [12:0] r_open_row [4];
  logic        r_row_err;
  logic        r_overflow;

  pkt_t                   r_pipe [CAS_LATENCY];
  logic [CAS_LATENCY-1:0] r_pipe_v;

  pkt_t        r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [2:0]  w_cmd;
  logic        w_cap;
  logic        w_is_rd;
  logic        w_is_rw;
  logic        w_push_imm;
  logic [12:0] w_bank_row;
  pkt_t        w_new;
  pkt_t        w_rd_pkt;
  pkt_t        w_head;
  logic        w_rd_done;
  logic        w_pop;
  logic [AW:0] w_free;
  logic        w_acc_rd;
  logic        w_acc_imm;
  logic        w_drop;

  assign w_cmd      = {sd_ras_n, sd_cas_n, sd_we_n};
  assign w_cap      = !sd_cs_n && (w_cmd != 3'b111);
  assign w_is_rd    = w_cap && (w_cmd == CMD_READ);
  assign w_is_rw    = w_cap && ((w_cmd == CMD_READ) || (w_cmd == CMD_WRITE));
  assign w_push_imm = w_cap && (w_cmd != CMD_READ);
  assign w_bank_row = r_open[sd_ba] ? r_open_row[sd_ba] : 13'd0;

  always_comb begin
    w_new      = '0;
    w_new.ts   = r_ts;
    w_new.id   = r_id;
    w_new.cmd  = w_cmd;
    w_new.bank = sd_ba;
    case (w_cmd)
      CMD_ACT, CMD_LMR: w_new.row = sd_addr;
      CMD_PRE:          w_new.row = w_bank_row;
      CMD_WRITE: begin
        w_new.row  = w_bank_row;
        w_new.col  = sd_addr[9:0];
        w_new.data = sd_dq;
      end
      CMD_READ: begin
        w_new.row = w_bank_row;
        w_new.col = sd_addr[9:0];
      end
      CMD_REF:  w_new.bank = 2'd0;
      default:  w_new.bank = sd_ba;
    endcase
  end

  // Read data is taken from the bus as the entry leaves the last pipeline stage.
  assign w_rd_done = r_pipe_v[CAS_LATENCY-1];
  always_comb begin
    w_rd_pkt      = r_pipe[CAS_LATENCY-1];
    w_rd_pkt.data = sd_dq;
  end

  // Free slots are counted after the same-cycle pop; the read completion wins a single slot.
  assign w_pop     = (r_count != '0) && pkt_ready;
  assign w_free    = (AW+1)'(FIFO_DEPTH - int'(r_count) + int'(w_pop));
  assign w_acc_rd  = w_rd_done && (w_free != '0);
  assign w_acc_imm = w_push_imm && (w_free > {{AW{1'b0}}, w_acc_rd});
  assign w_drop    = (w_rd_done && !w_acc_rd) || (w_push_imm && !w_acc_imm);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts       <= '0;
      r_id       <= '0;
      r_open     <= '0;
      r_row_err  <= 1'b0;
      r_overflow <= 1'b0;
      r_pipe_v   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_ts       <= r_ts + 32'd1;
      r_row_err  <= w_is_rw && !r_open[sd_ba];
      r_overflow <= r_overflow | w_drop;
      r_pipe_v   <= {r_pipe_v[CAS_LATENCY-2:0], w_is_rd};
      if (w_cap) r_id <= r_id + 32'd1;
      if (w_cap && (w_cmd == CMD_ACT)) r_open[sd_ba] <= 1'b1;
      if (w_cap && (w_cmd == CMD_PRE)) begin
        if (sd_addr[10]) r_open <= '0;
        else             r_open[sd_ba] <= 1'b0;
      end
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_wr_ptr <= r_wr_ptr + AW'(w_acc_rd) + AW'(w_acc_imm);
      r_count  <= r_count - (AW+1)'(w_pop) + (AW+1)'(w_acc_rd) + (AW+1)'(w_acc_imm);
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap && (w_cmd == CMD_ACT)) r_open_row[sd_ba] <= sd_addr;
    r_pipe[0] <= w_new;
    for (int i = 1; i < CAS_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    if (w_acc_rd)  r_mem[r_wr_ptr] <= w_rd_pkt;
    if (w_acc_imm) r_mem[w_acc_rd ? r_wr_ptr + AW'(1) : r_wr_ptr] <= w_new;
  end

  assign pkt_valid     = (r_count != '0);
  assign w_head        = pkt_valid ? r_mem[r_rd_ptr] : '0;
  assign pkt_timestamp = w_head.ts;
  assign pkt_id        = w_head.id;
  assign pkt_command   = w_head.cmd;
  assign pkt_bank      = w_head.bank;
  assign pkt_row       = w_head.row;
  assign pkt_column    = w_head.col;
  assign pkt_data      = w_head.data;
  assign row_err       = r_row_err;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Scoreboard bench for sdram_cmd_monitor: directed scenarios plus random command traffic
// checked against a transaction-level model of capture, read latency and buffering.
module tb_sdram_cmd_monitor;
  localparam int CL    = 3;
  localparam int DEPTH = 8;

  localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sd_cs_n = 1'b1, sd_ras_n = 1'b1, sd_cas_n = 1'b1, sd_we_n = 1'b1;
  logic [1:0]  sd_ba = '0;
  logic [12:0] sd_addr = '0;
  logic [15:0] sd_dq = '0;
  logic        pkt_ready = 1'b0;
  logic        pkt_valid;
  logic [31:0] pkt_timestamp, pkt_id;
  logic [2:0]  pkt_command;
  logic [1:0]  pkt_bank;
  logic [12:0] pkt_row;
  logic [9:0]  pkt_column;
  logic [15:0] pkt_data;
  logic        row_err, overflow;

  sdram_cmd_monitor #(.CAS_LATENCY(CL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .sd_cs_n(sd_cs_n), .sd_ras_n(sd_ras_n), .sd_cas_n(sd_cas_n), .sd_we_n(sd_we_n),
    .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_dq(sd_dq), .pkt_ready(pkt_ready),
    .pkt_valid(pkt_valid), .pkt_timestamp(pkt_timestamp), .pkt_id(pkt_id),
    .pkt_command(pkt_command), .pkt_bank(pkt_bank), .pkt_row(pkt_row),
    .pkt_column(pkt_column), .pkt_data(pkt_data), .row_err(row_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] id;
    logic [2:0]  cmd;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [9:0]  col;
    logic [15:0] data;
  } pkt_t;

  typedef struct {
    logic [31:0] due;
    pkt_t        p;
  } rd_t;

  pkt_t exp_q[$];
  rd_t  rd_q[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] m_ts;
  logic [31:0] m_id;
  int          m_occ;
  logic        m_ovf;
  logic        m_rerr;
  logic        m_open [4];
  logic [12:0] m_row  [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mpush(input pkt_t p);
    if (m_occ < DEPTH) begin
      m_occ++;
      exp_q.push_back(p);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    rd_q.delete();
    m_ts = '0; m_id = '0; m_occ = 0; m_ovf = 1'b0; m_rerr = 1'b0;
    for (int b = 0; b < 4; b++) begin
      m_open[b] = 1'b0;
      m_row[b]  = '0;
    end
  endtask

  // Drives one bus cycle (sampled at the next rising edge), advances the model,
  // then checks the single-cycle and sticky flags produced by that edge.
  task automatic step(input logic cs, input logic [2:0] cmd, input logic [1:0] ba,
                      input logic [12:0] addr, input logic [15:0] dq, input logic rdy);
    pkt_t p;
    rd_t  r;
    sd_cs_n = ~cs;
    {sd_ras_n, sd_cas_n, sd_we_n} = cmd;
    sd_ba = ba; sd_addr = addr; sd_dq = dq; pkt_ready = rdy;

    if (m_occ > 0 && rdy) m_occ--;
    if (rd_q.size() > 0 && rd_q[0].due == m_ts) begin
      r = rd_q.pop_front();
      p = r.p;
      p.data = dq;
      mpush(p);
    end
    m_rerr = 1'b0;
    if (cs && cmd != C_NOP) begin
      p = '0;
      p.ts = m_ts; p.id = m_id; p.cmd = cmd; p.bank = ba;
      m_id++;
      case (cmd)
        C_ACT: begin
          p.row = addr;
          m_open[ba] = 1'b1;
          m_row[ba]  = addr;
        end
        C_PRE: begin
          p.row = m_open[ba] ? m_row[ba] : 13'd0;
          if (addr[10]) for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
          else m_open[ba] = 1'b0;
        end
        C_WR, C_RD: begin
          m_rerr = !m_open[ba];
          p.row  = m_open[ba] ? m_row[ba] : 13'd0;
          p.col  = addr[9:0];
          if (cmd == C_WR) p.data = dq;
        end
        C_REF: p.bank = 2'd0;
        C_LMR: p.row = addr;
        default: ;
      endcase
      if (cmd == C_RD) begin
        r.due = m_ts + CL;
        r.p   = p;
        rd_q.push_back(r);
      end else begin
        mpush(p);
      end
    end
    m_ts++;

    @(posedge clk);
    #1;
    check("row_err", 128'(row_err), 128'(m_rerr));
    check("overflow", 128'(overflow), 128'(m_ovf));
  endtask

  task automatic nop(input logic rdy);
    step(1'b0, C_NOP, 2'd0, 13'd0, 16'($urandom), rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sd_cs_n = 1'b1; {sd_ras_n, sd_cas_n, sd_we_n} = C_NOP;
    pkt_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(pkt_valid), 128'(0));
    check("rst_id", 128'(pkt_id), 128'(0));
    check("rst_ts", 128'(pkt_timestamp), 128'(0));
    check("rst_row_err", 128'(row_err), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    reset = 1'b0;
  endtask

  // Monitor: every handshake pops the oldest expected packet and compares all fields.
  always @(negedge clk) begin
    pkt_t act;
    pkt_t exp;
    if (!reset && pkt_valid && pkt_ready) begin
      act = {pkt_timestamp, pkt_id, pkt_command, pkt_bank, pkt_row, pkt_column, pkt_data};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pkt: got %0h expected none at %0t", act, $time);
      end else begin
        exp = exp_q.pop_front();
        check("packet", 128'(act), 128'(exp));
        $display("pkt id=%0d cmd=%b bank=%0d row=%h col=%h data=%h ts=%0d",
                 act.id, act.cmd, act.bank, act.row, act.col, act.data, act.ts);
      end
    end
  end

  initial begin
    logic [2:0] c;
    do_reset();

    // First command lands at timestamp 5 and shows up one cycle later
    repeat (5) nop(1'b1);
    step(1'b1, C_ACT, 2'd1, 13'h0ABC, 16'h0, 1'b1);
    check("act_latency_valid", 128'(pkt_valid), 128'(1));

    step(1'b1, C_ACT, 2'd2, 13'h1234, 16'h0, 1'b1);
    step(1'b1, C_WR, 2'd2, 13'h0055, 16'hBEEF, 1'b1);

    // Read completion and a write in the same cycle: read must be ordered first
    step(1'b1, C_RD, 2'd2, 13'h0010, 16'h1111, 1'b1);
    nop(1'b1);
    nop(1'b1);
    step(1'b1, C_WR, 2'd2, 13'h0020, 16'hCAFE, 1'b1);
    check("rd_latency_valid", 128'(pkt_valid), 128'(1));
    repeat (3) nop(1'b1);

    // Precharge-all then read: row_err for one cycle, row reported as 0
    step(1'b1, C_PRE, 2'd0, 13'h0400, 16'h0, 1'b1);
    step(1'b1, C_RD, 2'd2, 13'h0033, 16'h0, 1'b1);
    repeat (CL + 2) nop(1'b1);

    // Ten writes with ready low: eight retained, overflow sticks, next id is 10
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, C_WR, 2'd0, 13'(i), 16'($urandom), 1'b0);
    repeat (10) nop(1'b1);
    step(1'b1, C_ACT, 2'd3, 13'h0777, 16'h0, 1'b1);
    repeat (3) nop(1'b1);

    // Reset with a read in flight discards it
    step(1'b1, C_ACT, 2'd1, 13'h0042, 16'h0, 1'b1);
    step(1'b1, C_RD, 2'd1, 13'h0001, 16'h0, 1'b1);
    nop(1'b1);
    do_reset();
    repeat (CL + 4) nop(1'b1);
    step(1'b1, C_LMR, 2'd0, 13'h0031, 16'h0, 1'b1);
    repeat (3) nop(1'b1);

    // Random traffic with random back-pressure
    for (int i = 0; i < 3000; i++) begin
      c = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 9) != 0), c, 2'($urandom), 13'($urandom), 16'($urandom),
           ($urandom_range(0, 9) < 7));
    end

    repeat (DEPTH + CL + 8) nop(1'b1);
    check("drain_exp_q_empty", 128'(exp_q.size()), 128'(0));
    check("drain_rd_q_empty", 128'(rd_q.size()), 128'(0));
    check("drain_valid_low", 128'(pkt_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
